// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial deserializer
//
// Purpose : assembler state encoding and bit-order selector constants,
//           imported by serial_deserializer and serial_out_slot.
// Contents: asm_state_e (ST_IDLE / ST_COLLECT / ST_HOLD),
//           LSB_FIRST / MSB_FIRST values for the msb_first input.

package serial_pkg;

  // Assembler states:
  //   ST_IDLE    - no bits of a frame held
  //   ST_COLLECT - 1..len-1 bits held
  //   ST_HOLD    - frame complete, waiting for the output slot to drain
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } asm_state_e;

  // Bit-order selector values for msb_first.
  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage : serial_pkg

// File: rtl/serial_out_slot.sv
// rtl/serial_out_slot.sv - single-entry valid/ready output register
//
// Purpose : holds one assembled frame (data + length) towards the consumer.
//           A new frame is loaded whenever the slot is empty or is being
//           drained on the same edge, so a full-rate producer sees no bubble.
// Ports   :
//   clock, reset           - clock, asynchronous active-high reset
//   push_valid_i           - producer offers a frame this cycle
//   push_data_i/push_len_i - offered frame contents
//   push_ready_o           - slot will take the offered frame on this edge
//   out_valid_o            - slot holds a frame
//   out_data_o/out_len_o   - held frame, stable while out_valid_o & !out_ready_i
//   out_ready_i            - consumer takes the frame this edge

import serial_pkg::*;

module serial_out_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [LEN_WIDTH-1:0]  push_len_i,
  output logic                  push_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [LEN_WIDTH-1:0]  out_len_o,
  input  logic                  out_ready_i
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  load;

  // Free when empty, or when the current frame leaves on this edge.
  assign push_ready_o = !valid_q || out_ready_i;
  assign load         = push_valid_i && push_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    len_d   = len_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = push_data_i;
      len_d   = push_len_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_len_o   = len_q;

endmodule : serial_out_slot

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial bit stream to parallel frame assembler
//
// Purpose : collects accepted serial bits into frames of a programmable
//           length (latched on the first bit), in LSB-first or MSB-first
//           order, and hands complete or flushed frames to an output slot.
// Ports   :
//   clock, reset         - clock, asynchronous active-high reset
//   frame_len, msb_first - frame length / bit order, sampled on first bit
//   in_valid, in_bit     - serial input, accepted when in_ready is high
//   in_ready             - low only while a finished frame waits (HOLD)
//   flush                - close the current partial frame
//   out_data, out_len    - assembled frame and its valid bit count
//   out_valid, out_ready - output handshake

import serial_pkg::*;

module serial_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  msb_first,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int                   IDX_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN  = LEN_WIDTH'(1);

  // Assembler registers. In HOLD, sh_q/cnt_q are reused to keep the
  // finished, already-ordered frame and its length until the slot frees.
  asm_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  msb_q, msb_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;

  logic                  accept;
  logic                  first;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic [LEN_WIDTH-1:0]  len_cur;
  logic                  msb_cur;
  logic [LEN_WIDTH-1:0]  cnt_new;
  logic [DATA_WIDTH-1:0] sh_new;
  logic [DATA_WIDTH-1:0] rev;
  logic [IDX_W-1:0]      src_idx;
  logic                  complete;
  logic                  flush_close;
  logic                  close;
  logic [DATA_WIDTH-1:0] frame_data;
  logic [LEN_WIDTH-1:0]  frame_len_out;

  logic                  slot_free;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [LEN_WIDTH-1:0]  push_len;

  // Depends on registered state only, never on out_ready.
  assign in_ready = (state_q != ST_HOLD);
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == ST_IDLE);

  // Zero or oversized requests mean a full-width frame.
  assign eff_len = ((frame_len == '0) || (frame_len > FULL_LEN)) ? FULL_LEN : frame_len;

  // Length and order come from the inputs on the first bit, then from the
  // latched copies so they cannot change mid-frame.
  assign len_cur = first ? eff_len   : len_q;
  assign msb_cur = first ? msb_first : msb_q;

  // Bits held after this edge.
  always_comb begin
    cnt_new = cnt_q;
    if (accept) begin
      cnt_new = first ? ONE_LEN : (cnt_q + ONE_LEN);
    end
  end

  // The shift register always shifts in at bit 0, so after n bits the
  // first bit sits at [n-1]: that is MSB-first relative to the count.
  always_comb begin
    sh_new = sh_q;
    if (accept) begin
      if (first) begin
        sh_new = {{(DATA_WIDTH-1){1'b0}}, in_bit};
      end else begin
        sh_new = {sh_q[DATA_WIDTH-2:0], in_bit};
      end
    end
  end

  // LSB-first view of a full frame: mirror the low len_cur bits.
  always_comb begin
    rev     = '0;
    src_idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(len_cur)) begin
        src_idx = IDX_W'(int'(len_cur) - 1 - i);
        rev[i]  = sh_new[src_idx];
      end
    end
  end

  // A normal completion wins over a flush arriving on the same edge.
  assign complete    = accept && (cnt_new == len_cur);
  assign flush_close = flush && ((state_q == ST_COLLECT) || (first && accept));
  assign close       = (state_q != ST_HOLD) && (complete || flush_close);

  assign frame_data    = (complete && (msb_cur == LSB_FIRST)) ? rev : sh_new;
  assign frame_len_out = complete ? len_cur : cnt_new;

  // Slot feed: a held frame in HOLD, otherwise the frame closing now.
  assign push_valid = (state_q == ST_HOLD) || close;
  assign push_data  = (state_q == ST_HOLD) ? sh_q  : frame_data;
  assign push_len   = (state_q == ST_HOLD) ? cnt_q : frame_len_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    msb_d   = msb_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          len_d = len_cur;
          msb_d = msb_cur;
        end
        if (close) begin
          if (slot_free) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = frame_len_out;
            sh_d    = frame_data;
          end
        end else if (accept) begin
          state_d = ST_COLLECT;
          cnt_d   = cnt_new;
          sh_d    = sh_new;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      msb_q   <= LSB_FIRST;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      sh_q    <= sh_d;
    end
  end

  serial_out_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_out_slot (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (push_valid),
    .push_data_i  (push_data),
    .push_len_i   (push_len),
    .push_ready_o (slot_free),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_len_o    (out_len),
    .out_ready_i  (out_ready)
  );

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - self-checking bench for serial_deserializer

module tb_serial_deserializer;

  logic        clock;
  logic        reset;
  logic [5:0]  frame_len;
  logic        msb_first;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic [5:0]  out_len;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  serial_deserializer #(
    .DATA_WIDTH (32),
    .LEN_WIDTH  (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_len (frame_len),
    .msb_first (msb_first),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [5:0]  len;
    logic        msb;
    int          nbits;
    logic [31:0] bits;      // bit k is the k-th serial bit sent
    logic [31:0] exp_data;
    logic [5:0]  exp_len;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Send nbits of bits (LSB of the vector first) back to back.
  task automatic send_bits(input int nbits, input logic [31:0] bits);
    logic [31:0] b;
    b = bits;
    for (int k = 0; k < nbits; k++) begin
      in_valid = 1'b1;
      in_bit   = b[k];
      chk("in_ready_while_sending", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{len: 6'd8,  msb: 1'b0, nbits: 8,  bits: 32'h0000_008D, exp_data: 32'h0000_008D, exp_len: 6'd8};
    vecs[1] = '{len: 6'd8,  msb: 1'b1, nbits: 8,  bits: 32'h0000_008D, exp_data: 32'h0000_00B1, exp_len: 6'd8};
    vecs[2] = '{len: 6'd0,  msb: 1'b0, nbits: 32, bits: 32'h1234_5678, exp_data: 32'h1234_5678, exp_len: 6'd32};
    vecs[3] = '{len: 6'd40, msb: 1'b1, nbits: 32, bits: 32'h0000_000F, exp_data: 32'hF000_0000, exp_len: 6'd32};
    vecs[4] = '{len: 6'd1,  msb: 1'b0, nbits: 1,  bits: 32'h0000_0001, exp_data: 32'h0000_0001, exp_len: 6'd1};
    vecs[5] = '{len: 6'd1,  msb: 1'b1, nbits: 1,  bits: 32'h0000_0001, exp_data: 32'h0000_0001, exp_len: 6'd1};
    vecs[6] = '{len: 6'd5,  msb: 1'b1, nbits: 5,  bits: 32'h0000_0006, exp_data: 32'h0000_000C, exp_len: 6'd5};
    vecs[7] = '{len: 6'd32, msb: 1'b0, nbits: 32, bits: 32'hDEAD_BEEF, exp_data: 32'hDEAD_BEEF, exp_len: 6'd32};

    reset     = 1'b1;
    frame_len = 6'd8;
    msb_first = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  out_data,       32'd0);
    chk("reset_out_len",   32'(out_len),   32'd0);
    reset = 1'b0;
    step();
    chk("reset_in_ready",  32'(in_ready),  32'd1);

    // Table: frames back to back with out_ready high, no idle cycle between.
    for (int v = 0; v < 8; v++) begin
      logic [31:0] b;
      b         = vecs[v].bits;
      frame_len = vecs[v].len;
      msb_first = vecs[v].msb;
      for (int k = 0; k < vecs[v].nbits; k++) begin
        in_valid = 1'b1;
        in_bit   = b[k];
        if (k == vecs[v].nbits - 1 && vecs[v].nbits > 1)
          chk($sformatf("vec%0d_valid_before_last", v), 32'(out_valid), 32'd0);
        chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'd1);
        step();
      end
      chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_out_data", v),  out_data,       vecs[v].exp_data);
      chk($sformatf("vec%0d_out_len", v),   32'(out_len),   32'(vecs[v].exp_len));
    end
    in_valid = 1'b0;
    step();
    chk("table_drained", 32'(out_valid), 32'd0);

    // Stalled consumer: first frame held, second frame parks in HOLD.
    out_ready = 1'b0;
    frame_len = 6'd4;
    msb_first = 1'b0;
    send_bits(4, 32'h1);
    chk("stall_f1_valid", 32'(out_valid), 32'd1);
    chk("stall_f1_data",  out_data,       32'h1);
    send_bits(4, 32'hE);
    chk("stall_hold_in_ready", 32'(in_ready), 32'd0);
    chk("stall_f1_data_held",  out_data,      32'h1);
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      step();
      chk("stall_hold_in_ready_loop", 32'(in_ready), 32'd0);
      chk("stall_f1_stable_data",     out_data,      32'h1);
      chk("stall_f1_stable_len",      32'(out_len),  32'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_f2_valid",    32'(out_valid), 32'd1);
    chk("stall_f2_data",     out_data,       32'hE);
    chk("stall_f2_len",      32'(out_len),   32'd4);
    chk("stall_f2_in_ready", 32'(in_ready),  32'd1);
    step();
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Flush of a partial frame, separate cycle.
    frame_len = 6'd16;
    msb_first = 1'b0;
    send_bits(5, 32'h0B);  // bits 1,1,0,1,0
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_data",  out_data,       32'h1A);
    chk("flush_len",   32'(out_len),   32'd5);

    // Fresh frame afterwards.
    frame_len = 6'd4;
    send_bits(4, 32'h3);
    chk("after_flush_data", out_data,     32'h3);
    chk("after_flush_len",  32'(out_len), 32'd4);

    // Flush in IDLE with a bit accepted: 1-bit frame.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    flush    = 1'b1;
    step();
    chk("flush_idle_bit_valid", 32'(out_valid), 32'd1);
    chk("flush_idle_bit_data",  out_data,       32'h1);
    chk("flush_idle_bit_len",   32'(out_len),   32'd1);

    // Flush in IDLE without a bit: ignored.
    in_valid = 1'b0;
    step();
    flush = 1'b0;
    chk("flush_idle_ignored", 32'(out_valid), 32'd0);
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);

    // Flush in COLLECT together with a bit: the bit is counted.
    frame_len = 6'd8;
    send_bits(2, 32'h1);   // bits 1,0
    in_valid = 1'b1;
    in_bit   = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_same_edge_data", out_data,     32'h5);
    chk("flush_same_edge_len",  32'(out_len), 32'd3);
    step();

    // Reset with a frame in the slot and a partial frame: takes effect at once.
    out_ready = 1'b0;
    frame_len = 6'd2;
    send_bits(2, 32'h3);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    frame_len = 6'd8;
    send_bits(3, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_data",  out_data,       32'd0);
    chk("async_reset_len",   32'(out_len),   32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_reset_valid",    32'(out_valid), 32'd0);
    chk("post_reset_in_ready", 32'(in_ready),  32'd1);
    frame_len = 6'd8;
    msb_first = 1'b0;
    begin
      logic [31:0] b;
      b = 32'h5A;
      for (int k = 0; k < 8; k++) begin
        in_valid = 1'b1;
        in_bit   = b[k];
        if (k == 7) chk("post_reset_valid_before_last", 32'(out_valid), 32'd0);
        step();
      end
    end
    in_valid = 1'b0;
    chk("post_reset_frame_valid", 32'(out_valid), 32'd1);
    chk("post_reset_frame_data",  out_data,       32'h5A);
    chk("post_reset_frame_len",   32'(out_len),   32'd8);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_deserializer
